pdp8_ram_arb: RTL and testbench
===============================

Name: pdp8_ram_arb

Overview:
Two-port arbiter that shares the single pdp8_ram port between the pdp8 CPU memory interface and the pdp8_io DMA interface (the ext_ram_* signals). It sequences every access as a fixed-length RAM cycle, captures read data and returns a one-cycle acknowledge to the winning requester. Sits between the cpu, io and ram instances at top level, on the divided clk domain.

Parameters:
ADDR_W, 15, RAM word address width (32K x 12 field-extended memory)
DATA_W, 12, word width
RAM_LAT, 2, cycles ram_rd/ram_wr held with stable address; read data sampled on the last of these (legal range 1..15)
STARVE_MAX, 4, consecutive CPU grants allowed while DMA is pending before DMA is forced to win; 0 = DMA strict priority

Ports:
clk  in  1  system clock (divided clk from top)
reset  in  1  asynchronous, active-high reset
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_rd  in  1  CPU read request, level, held until cpu_ack
cpu_wr  in  1  CPU write request, level, held until cpu_ack
cpu_rdata  out  DATA_W  CPU read data, valid in ack cycle, held until next CPU read completes
cpu_ack  out  1  one-cycle completion pulse
dma_ma  in  ADDR_W  DMA address
dma_wdata  in  DATA_W  DMA write data
dma_read_req  in  1  DMA read request, level, held until dma_done
dma_write_req  in  1  DMA write request, level, held until dma_done
dma_rdata  out  DATA_W  DMA read data, valid in done cycle, held
dma_done  out  1  one-cycle completion pulse
ram_addr  out  ADDR_W  to pdp8_ram addr
ram_wdata  out  DATA_W  to pdp8_ram data_in
ram_rdata  in  DATA_W  from pdp8_ram data_out
ram_rd  out  1  RAM read strobe
ram_wr  out  1  RAM write strobe

Behaviour:
- Single clk; reset asynchronous, active-high. Reset: state IDLE; ram_rd, ram_wr, cpu_ack, dma_done = 0; ram_addr, ram_wdata, cpu_rdata, dma_rdata = 0; starve counter = 0.
- FSM states: IDLE, ACC, ACK. All outputs registered.
- IDLE: sample requests. Neither -> stay. One port -> grant it. Both -> CPU wins unless starve counter == STARVE_MAX, then DMA wins. Grant latches owner, address, write data, op; next state ACC, beat counter = 0.
- Op per port: write if wr-type request set, else read; rd and wr both high = write (rd ignored).
- ACC: ram_addr/ram_wdata stable; exactly one of ram_rd/ram_wr high for RAM_LAT cycles. On the last beat (counter == RAM_LAT-1) a read samples ram_rdata into the owner's rdata register; next state ACK.
- ACK: strobes low; owner's ack/done high for exactly one cycle; next state IDLE. Requester deasserts its request at the edge ending ACK; a request still high in IDLE is a new access.
- Latency: request seen in IDLE at edge N -> ack high in cycle N+RAM_LAT+1. Throughput: one access per RAM_LAT+2 cycles.
- Starve counter: +1 on each CPU grant while a DMA request is pending (saturates at STARVE_MAX); cleared on DMA grant or when no DMA request in IDLE.
- Requests changing during ACC are ignored (latched copies used). Non-owner rdata unchanged.
- Reset mid-access: immediate return to IDLE, strobes drop asynchronously, no ack/done issued; requester reissues.

Optional Feature:
PDP8_RAM_ARB_STATS_EN: adds input stats_clr (1) and outputs cpu_grants, dma_grants (16 bits each), incremented on each grant, saturating at 16'hffff, cleared by reset or stats_clr (clear wins over same-cycle increment). Without macro: ports and counters absent; behaviour otherwise identical.

Test Plan:
- CPU write 0o1234 to 0o00200, then read 0o00200 (RAM_LAT=2) -> ram_wr high 2 cycles, cpu_ack 3 cycles after request sample; read returns cpu_rdata=0o1234.
- DMA read of 0o17777 holding 0o5252 -> dma_rdata=0o5252 with dma_done single pulse; cpu_ack stays 0.
- CPU and DMA requests both raised continuously, STARVE_MAX=4 -> grant order CPU x4, DMA, CPU x4, DMA; no port waits longer than 5 access slots.
- STARVE_MAX=0 with simultaneous requests -> DMA granted first every time.
- Assert reset during ACC beat 1 of a CPU write -> ram_wr drops immediately, no cpu_ack, FSM in IDLE, all outputs 0.
- cpu_rd and cpu_wr both high with cpu_wdata=0o7777 -> treated as write, ram_rd never asserted; with PDP8_RAM_ARB_STATS_EN, cpu_grants increments by 1.

Source files
------------

// File: rtl/pdp8_ram_arb_if.sv
// Bus bundle between the pdp8 CPU, the pdp8_io DMA port and pdp8_ram around pdp8_ram_arb.
// slave = arbiter view, master = surrounding top-level view. PDP8_RAM_ARB_STATS_EN adds grant statistics.
interface pdp8_ram_arb_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 12
);
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_rd;
  logic              cpu_wr;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic [ADDR_W-1:0] dma_ma;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_read_req;
  logic              dma_write_req;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_done;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_rd;
  logic              ram_wr;
`ifdef PDP8_RAM_ARB_STATS_EN
  logic              stats_clr;
  logic [15:0]       cpu_grants;
  logic [15:0]       dma_grants;
`endif

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
    input  dma_ma, dma_wdata, dma_read_req, dma_write_req,
    input  ram_rdata,
`ifdef PDP8_RAM_ARB_STATS_EN
    input  stats_clr,
    output cpu_grants, dma_grants,
`endif
    output cpu_rdata, cpu_ack, dma_rdata, dma_done,
    output ram_addr, ram_wdata, ram_rd, ram_wr
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
    output dma_ma, dma_wdata, dma_read_req, dma_write_req,
    output ram_rdata,
`ifdef PDP8_RAM_ARB_STATS_EN
    output stats_clr,
    input  cpu_grants, dma_grants,
`endif
    input  cpu_rdata, cpu_ack, dma_rdata, dma_done,
    input  ram_addr, ram_wdata, ram_rd, ram_wr
  );
endinterface

// File: rtl/pdp8_ram_arb.sv
// Shares the single pdp8_ram port between the CPU and the DMA port with fixed-length RAM cycles.
// Optional PDP8_RAM_ARB_STATS_EN adds saturating per-port grant counters with a clear input.
module pdp8_ram_arb #(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned RAM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           reset,
  pdp8_ram_arb_if.slave  bus
);
  localparam int unsigned BEAT_W = 4;
  localparam int unsigned STV_W  = $clog2(STARVE_MAX + 2);

  typedef enum logic [1:0] {IDLE, ACC, ACK} state_t;

  state_t            state;
  logic [BEAT_W-1:0] beat;
  logic [STV_W-1:0]  starve;
  logic              own_dma;
  logic              cpu_req;
  logic              dma_req;
  logic              dma_win;

  assign cpu_req = bus.cpu_rd | bus.cpu_wr;
  assign dma_req = bus.dma_read_req | bus.dma_write_req;
  // DMA wins alone, or when the CPU has used up its consecutive-grant allowance.
  assign dma_win = dma_req & (~cpu_req | (starve == STV_W'(STARVE_MAX)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      beat          <= '0;
      starve        <= '0;
      own_dma       <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      bus.ram_rd    <= 1'b0;
      bus.ram_wr    <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.dma_rdata <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.dma_done  <= 1'b0;
    end else begin
      bus.cpu_ack  <= 1'b0;
      bus.dma_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!dma_req) begin
            starve <= '0;
          end
          if (cpu_req || dma_req) begin
            state   <= ACC;
            beat    <= '0;
            own_dma <= dma_win;
            if (dma_win) begin
              bus.ram_addr  <= bus.dma_ma;
              bus.ram_wdata <= bus.dma_wdata;
              bus.ram_wr    <= bus.dma_write_req;
              bus.ram_rd    <= ~bus.dma_write_req;
              starve        <= '0;
            end else begin
              bus.ram_addr  <= bus.cpu_addr;
              bus.ram_wdata <= bus.cpu_wdata;
              bus.ram_wr    <= bus.cpu_wr;
              bus.ram_rd    <= ~bus.cpu_wr;
              if (dma_req && (starve != STV_W'(STARVE_MAX))) begin
                starve <= starve + STV_W'(1);
              end
            end
          end
        end
        ACC: begin
          if (beat == BEAT_W'(RAM_LAT - 1)) begin
            // Last beat: capture read data for the owner only and raise its acknowledge.
            if (bus.ram_rd) begin
              if (own_dma) bus.dma_rdata <= bus.ram_rdata;
              else         bus.cpu_rdata <= bus.ram_rdata;
            end
            bus.ram_rd <= 1'b0;
            bus.ram_wr <= 1'b0;
            if (own_dma) bus.dma_done <= 1'b1;
            else         bus.cpu_ack  <= 1'b1;
            state <= ACK;
          end else begin
            beat <= beat + BEAT_W'(1);
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PDP8_RAM_ARB_STATS_EN
  logic grant;
  assign grant = (state == IDLE) & (cpu_req | dma_req);

  // Clear has priority over an increment in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.cpu_grants <= '0;
      bus.dma_grants <= '0;
    end else if (bus.stats_clr) begin
      bus.cpu_grants <= '0;
      bus.dma_grants <= '0;
    end else if (grant) begin
      if (dma_win && (bus.dma_grants != 16'hffff)) begin
        bus.dma_grants <= bus.dma_grants + 16'd1;
      end
      if (!dma_win && (bus.cpu_grants != 16'hffff)) begin
        bus.cpu_grants <= bus.cpu_grants + 16'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_pdp8_ram_arb.sv
// Directed self-checking bench for pdp8_ram_arb (RAM_LAT=2, STARVE_MAX=4 and a STARVE_MAX=0 copy).
module tb_pdp8_ram_arb;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pdp8_ram_arb_if #(.ADDR_W(15), .DATA_W(12)) bus ();
  pdp8_ram_arb_if #(.ADDR_W(15), .DATA_W(12)) bus0 ();

  pdp8_ram_arb #(.ADDR_W(15), .DATA_W(12), .RAM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
  pdp8_ram_arb #(.ADDR_W(15), .DATA_W(12), .RAM_LAT(2), .STARVE_MAX(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));

  logic [11:0] mem [0:32767];
  assign bus.ram_rdata  = mem[bus.ram_addr];
  assign bus0.ram_rdata = 12'o0;

  always @(posedge clk) begin
    if (reset)           mem[15'o17777] <= 12'o5252;
    else if (bus.ram_wr) mem[bus.ram_addr] <= bus.ram_wdata;
  end

  // Drives one request on the main DUT, counts strobe cycles until its ack, then drops it.
  task automatic access(input bit dma, input logic [14:0] addr, input logic [11:0] wd,
                        input bit rd, input bit wr,
                        output int lat, output int rd_n, output int wr_n, output int other_n);
    @(negedge clk);
    if (dma) begin
      bus.dma_ma = addr; bus.dma_wdata = wd; bus.dma_read_req = rd; bus.dma_write_req = wr;
    end else begin
      bus.cpu_addr = addr; bus.cpu_wdata = wd; bus.cpu_rd = rd; bus.cpu_wr = wr;
    end
    lat = -1; rd_n = 0; wr_n = 0; other_n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.ram_rd) rd_n++;
      if (bus.ram_wr) wr_n++;
      if (dma ? bus.cpu_ack : bus.dma_done) other_n++;
      if (dma ? bus.dma_done : bus.cpu_ack) begin lat = i; break; end
    end
    @(negedge clk);
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.dma_read_req = 1'b0; bus.dma_write_req = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({bus.ram_rd, bus.ram_wr, bus.cpu_ack, bus.dma_done} !== 4'b0) begin
      n_bad++; $display("FAIL reset_strobes got=%b exp=0000", {bus.ram_rd, bus.ram_wr, bus.cpu_ack, bus.dma_done});
    end
    n_cmp++;
    if ({bus.ram_addr, bus.ram_wdata, bus.cpu_rdata, bus.dma_rdata} !== 51'd0) begin
      n_bad++; $display("FAIL reset_data got=%h exp=0", {bus.ram_addr, bus.ram_wdata, bus.cpu_rdata, bus.dma_rdata});
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_cpu_write_read();
    int lat, rd_n, wr_n, oth;
    access(1'b0, 15'o00200, 12'o1234, 1'b0, 1'b1, lat, rd_n, wr_n, oth);
    n_cmp++;
    if (lat !== 3) begin n_bad++; $display("FAIL cpu_wr_latency got=%0d exp=3", lat); end
    n_cmp++;
    if (wr_n !== 2 || rd_n !== 0) begin n_bad++; $display("FAIL cpu_wr_strobes got wr=%0d rd=%0d exp wr=2 rd=0", wr_n, rd_n); end
    n_cmp++;
    if (mem[15'o00200] !== 12'o1234) begin n_bad++; $display("FAIL cpu_wr_mem got=%o exp=1234", mem[15'o00200]); end
    access(1'b0, 15'o00200, 12'o0, 1'b1, 1'b0, lat, rd_n, wr_n, oth);
    n_cmp++;
    if (lat !== 3 || rd_n !== 2 || wr_n !== 0) begin
      n_bad++; $display("FAIL cpu_rd_timing got lat=%0d rd=%0d wr=%0d exp 3/2/0", lat, rd_n, wr_n);
    end
    n_cmp++;
    if (bus.cpu_rdata !== 12'o1234) begin n_bad++; $display("FAIL cpu_rdata got=%o exp=1234", bus.cpu_rdata); end
    n_cmp++;
    if (bus.dma_rdata !== 12'o0) begin n_bad++; $display("FAIL dma_rdata_untouched got=%o exp=0", bus.dma_rdata); end
  endtask

  task automatic test_dma_read();
    int lat, rd_n, wr_n, oth;
    access(1'b1, 15'o17777, 12'o0, 1'b1, 1'b0, lat, rd_n, wr_n, oth);
    n_cmp++;
    if (lat !== 3 || rd_n !== 2) begin n_bad++; $display("FAIL dma_rd_timing got lat=%0d rd=%0d exp 3/2", lat, rd_n); end
    n_cmp++;
    if (bus.dma_rdata !== 12'o5252) begin n_bad++; $display("FAIL dma_rdata got=%o exp=5252", bus.dma_rdata); end
    n_cmp++;
    if (oth !== 0) begin n_bad++; $display("FAIL dma_cpu_ack_quiet got=%0d exp=0", oth); end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.dma_done !== 1'b0) begin n_bad++; $display("FAIL dma_done_pulse got=%b exp=0", bus.dma_done); end
    n_cmp++;
    if (bus.cpu_rdata !== 12'o1234) begin n_bad++; $display("FAIL cpu_rdata_held got=%o exp=1234", bus.cpu_rdata); end
  endtask

  task automatic test_rd_wr_both();
    int lat, rd_n, wr_n, oth;
`ifdef PDP8_RAM_ARB_STATS_EN
    logic [15:0] g0;
    g0 = bus.cpu_grants;
`endif
    access(1'b0, 15'o00300, 12'o7777, 1'b1, 1'b1, lat, rd_n, wr_n, oth);
    n_cmp++;
    if (rd_n !== 0 || wr_n !== 2 || lat !== 3) begin
      n_bad++; $display("FAIL both_rd_wr got rd=%0d wr=%0d lat=%0d exp 0/2/3", rd_n, wr_n, lat);
    end
    n_cmp++;
    if (mem[15'o00300] !== 12'o7777) begin n_bad++; $display("FAIL both_rd_wr_mem got=%o exp=7777", mem[15'o00300]); end
    n_cmp++;
    if (bus.cpu_rdata !== 12'o1234) begin n_bad++; $display("FAIL both_rd_wr_rdata got=%o exp=1234", bus.cpu_rdata); end
`ifdef PDP8_RAM_ARB_STATS_EN
    n_cmp++;
    if (bus.cpu_grants !== g0 + 16'd1) begin
      n_bad++; $display("FAIL cpu_grants got=%0d exp=%0d", bus.cpu_grants, g0 + 16'd1);
    end
`endif
  endtask

  task automatic test_starve();
    string exp_seq;
    byte   seq [10];
    int    n;
    int    both;
    exp_seq = "CCCCDCCCCD";
    n = 0; both = 0;
    @(negedge clk);
    bus.cpu_addr = 15'o01000; bus.cpu_rd = 1'b1;
    bus.dma_ma = 15'o02000; bus.dma_read_req = 1'b1;
    for (int i = 0; i < 200 && n < 10; i++) begin
      @(posedge clk); #1;
      if (bus.cpu_ack && bus.dma_done) both++;
      if (bus.cpu_ack)       begin seq[n] = "C"; n++; end
      else if (bus.dma_done) begin seq[n] = "D"; n++; end
    end
    @(negedge clk);
    bus.cpu_rd = 1'b0; bus.dma_read_req = 1'b0;
    n_cmp++;
    if (n !== 10 || both !== 0) begin n_bad++; $display("FAIL starve_count got=%0d both=%0d exp=10 both=0", n, both); end
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (seq[i] !== exp_seq[i]) begin
        n_bad++; $display("FAIL starve_order[%0d] got=%c exp=%c", i, seq[i], exp_seq[i]);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_strict_dma();
    int n_dma, n_cpu;
    n_dma = 0; n_cpu = 0;
    @(negedge clk);
    bus0.cpu_addr = 15'o00100; bus0.cpu_rd = 1'b1;
    bus0.dma_ma = 15'o00500; bus0.dma_read_req = 1'b1;
    for (int i = 0; i < 100 && n_dma < 3; i++) begin
      @(posedge clk); #1;
      if (bus0.cpu_ack)  n_cpu++;
      if (bus0.dma_done) n_dma++;
    end
    @(negedge clk);
    bus0.cpu_rd = 1'b0; bus0.dma_read_req = 1'b0;
    n_cmp++;
    if (n_dma !== 3 || n_cpu !== 0) begin
      n_bad++; $display("FAIL strict_dma got dma=%0d cpu=%0d exp dma=3 cpu=0", n_dma, n_cpu);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    int lat, rd_n, wr_n, oth;
    int acks;
    @(negedge clk);
    bus.cpu_addr = 15'o00400; bus.cpu_wdata = 12'o1111; bus.cpu_wr = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.ram_wr !== 1'b1) begin n_bad++; $display("FAIL mid_pre_wr got=%b exp=1", bus.ram_wr); end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.ram_wr, bus.ram_rd, bus.cpu_ack, bus.dma_done} !== 4'b0) begin
      n_bad++; $display("FAIL mid_strobes got=%b exp=0000", {bus.ram_wr, bus.ram_rd, bus.cpu_ack, bus.dma_done});
    end
    n_cmp++;
    if ({bus.ram_addr, bus.ram_wdata, bus.cpu_rdata, bus.dma_rdata} !== 51'd0) begin
      n_bad++; $display("FAIL mid_data got=%h exp=0", {bus.ram_addr, bus.ram_wdata, bus.cpu_rdata, bus.dma_rdata});
    end
    bus.cpu_wr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    acks = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.cpu_ack || bus.ram_wr) acks++;
    end
    n_cmp++;
    if (acks !== 0) begin n_bad++; $display("FAIL mid_no_ack got=%0d exp=0", acks); end
    access(1'b0, 15'o00200, 12'o0, 1'b1, 1'b0, lat, rd_n, wr_n, oth);
    n_cmp++;
    if (lat !== 3 || bus.cpu_rdata !== 12'o1234) begin
      n_bad++; $display("FAIL mid_reissue got lat=%0d rdata=%o exp 3/1234", lat, bus.cpu_rdata);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
    bus.dma_ma = '0; bus.dma_wdata = '0; bus.dma_read_req = 1'b0; bus.dma_write_req = 1'b0;
    bus0.cpu_addr = '0; bus0.cpu_wdata = '0; bus0.cpu_rd = 1'b0; bus0.cpu_wr = 1'b0;
    bus0.dma_ma = '0; bus0.dma_wdata = '0; bus0.dma_read_req = 1'b0; bus0.dma_write_req = 1'b0;
`ifdef PDP8_RAM_ARB_STATS_EN
    bus.stats_clr = 1'b0;
    bus0.stats_clr = 1'b0;
`endif
    test_reset();
    test_cpu_write_read();
    test_dma_read();
    test_rd_wr_both();
    test_starve();
    test_strict_dma();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
